// File: rtl/idelay_calib_ctrl_pkg.sv
// Shared defaults and types for the IDELAY calibration / tap control block.
package idelay_calib_ctrl_pkg;

    localparam int unsigned NUM_LANES   = 11;
    localparam int unsigned TAP_W       = 9;
    localparam int unsigned TAP_DEFAULT = 256;
    localparam int unsigned CAL_CYCLES  = 64;
    localparam int unsigned LANE_W      = 4;

    typedef enum logic {
        CAL,
        READY
    } cal_state_t;

endpackage

// File: rtl/idelay_calib_ctrl_calib_timer.sv
// Calibration timer: holds o_rdy low for CAL_CYCLES edges after reset or a recal request.
module idelay_calib_ctrl_calib_timer #(
    parameter int unsigned CAL_CYCLES = idelay_calib_ctrl_pkg::CAL_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_recal,
    output logic o_rdy
);
    import idelay_calib_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(CAL_CYCLES + 1);

    cal_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= CAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_recal) begin
            state_d = CAL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                CAL: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CAL_CYCLES - 1)) begin
                        state_d = READY;
                    end
                end
                READY:   cnt_d = cnt_q;
                default: state_d = CAL;
            endcase
        end
    end

    always_comb begin
        o_rdy = (state_q == READY);
    end

endmodule

// File: rtl/idelay_calib_ctrl.sv
// IDELAY control: calibration ready flag plus per-lane tap register bank.
// Optional macro IDELAY_TAP_INCDEC_EN adds saturating per-lane increment/decrement.
module idelay_calib_ctrl #(
    parameter int unsigned NUM_LANES   = idelay_calib_ctrl_pkg::NUM_LANES,
    parameter int unsigned TAP_W       = idelay_calib_ctrl_pkg::TAP_W,
    parameter int unsigned TAP_DEFAULT = idelay_calib_ctrl_pkg::TAP_DEFAULT,
    parameter int unsigned CAL_CYCLES  = idelay_calib_ctrl_pkg::CAL_CYCLES
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_recal,
    input  logic                       i_tap_wr_en,
`ifdef IDELAY_TAP_INCDEC_EN
    input  logic                       i_tap_inc,
    input  logic                       i_tap_dec,
`endif
    input  logic [3:0]                 i_tap_lane,
    input  logic [TAP_W-1:0]           i_tap_value,
    output logic                       o_rdy,
    output logic [NUM_LANES*TAP_W-1:0] o_tap_flat,
    output logic                       o_tap_load,
    output logic [3:0]                 o_tap_load_lane,
    output logic                       o_err
);
    import idelay_calib_ctrl_pkg::*;

    logic             rdy;
    logic [TAP_W-1:0] tap_q [NUM_LANES];
    logic [TAP_W-1:0] tap_d [NUM_LANES];
    logic             load_q, err_q;
    logic [3:0]       load_lane_q;
    logic             any_req, multi_req, lane_ok, accept, reject;

    idelay_calib_ctrl_calib_timer #(
        .CAL_CYCLES (CAL_CYCLES)
    ) u_calib_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_recal (i_recal),
        .o_rdy   (rdy)
    );

    always_comb begin
`ifdef IDELAY_TAP_INCDEC_EN
        any_req   = i_tap_wr_en | i_tap_inc | i_tap_dec;
        multi_req = (i_tap_wr_en & i_tap_inc) | (i_tap_wr_en & i_tap_dec) |
                    (i_tap_inc & i_tap_dec);
`else
        any_req   = i_tap_wr_en;
        multi_req = 1'b0;
`endif
        lane_ok = (32'(i_tap_lane) < NUM_LANES);
        // Recal takes priority: a coincident write is dropped and flagged.
        accept  = any_req && !multi_req && rdy && !i_recal && lane_ok;
        reject  = any_req && !accept;
    end

    always_comb begin
        for (int unsigned n = 0; n < NUM_LANES; n++) begin
            tap_d[n] = tap_q[n];
            if (accept && (i_tap_lane == 4'(n))) begin
`ifdef IDELAY_TAP_INCDEC_EN
                if (i_tap_inc) begin
                    tap_d[n] = (&tap_q[n]) ? tap_q[n] : tap_q[n] + TAP_W'(1);
                end else if (i_tap_dec) begin
                    tap_d[n] = (tap_q[n] == '0) ? tap_q[n] : tap_q[n] - TAP_W'(1);
                end else begin
                    tap_d[n] = i_tap_value;
                end
`else
                tap_d[n] = i_tap_value;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned n = 0; n < NUM_LANES; n++) begin
                tap_q[n] <= TAP_W'(TAP_DEFAULT);
            end
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            load_lane_q <= '0;
        end else begin
            for (int unsigned n = 0; n < NUM_LANES; n++) begin
                tap_q[n] <= tap_d[n];
            end
            load_q <= accept;
            err_q  <= reject;
            if (accept) begin
                load_lane_q <= i_tap_lane;
            end
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < NUM_LANES; n++) begin
            o_tap_flat[n*TAP_W +: TAP_W] = tap_q[n];
        end
        o_rdy           = rdy;
        o_tap_load      = load_q;
        o_tap_load_lane = load_lane_q;
        o_err           = err_q;
    end

endmodule

// File: tb/tb_idelay_calib_ctrl.sv
// Self-checking bench for idelay_calib_ctrl: cycle model plus directed literal checks.
module tb_idelay_calib_ctrl;
    import idelay_calib_ctrl_pkg::*;

    localparam int unsigned FW = NUM_LANES * TAP_W;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_recal = 1'b0;
    logic          i_tap_wr_en = 1'b0;
    logic          i_tap_inc = 1'b0;
    logic          i_tap_dec = 1'b0;
    logic [3:0]    i_tap_lane = '0;
    logic [TAP_W-1:0] i_tap_value = '0;
    logic          o_rdy;
    logic [FW-1:0] o_tap_flat;
    logic          o_tap_load;
    logic [3:0]    o_tap_load_lane;
    logic          o_err;

    int checks = 0;
    int fails  = 0;
    bit started = 1'b0;

    idelay_calib_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_recal         (i_recal),
        .i_tap_wr_en     (i_tap_wr_en),
`ifdef IDELAY_TAP_INCDEC_EN
        .i_tap_inc       (i_tap_inc),
        .i_tap_dec       (i_tap_dec),
`endif
        .i_tap_lane      (i_tap_lane),
        .i_tap_value     (i_tap_value),
        .o_rdy           (o_rdy),
        .o_tap_flat      (o_tap_flat),
        .o_tap_load      (o_tap_load),
        .o_tap_load_lane (o_tap_load_lane),
        .o_err           (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ready once at least CAL_CYCLES clean edges have passed since reset/recal.
    int          m_age;
    int          m_tap [NUM_LANES];
    bit          m_load, m_err;
    int          m_lane;
    int          m_ops, m_v;
    bit          m_ok;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_age  = 0;
            m_load = 0;
            m_err  = 0;
            m_lane = 0;
            for (int l = 0; l < NUM_LANES; l++) m_tap[l] = TAP_DEFAULT;
        end else begin
            m_ops = int'(i_tap_wr_en) + int'(i_tap_inc) + int'(i_tap_dec);
            m_ok  = (m_ops == 1) && (m_age >= CAL_CYCLES) && !i_recal &&
                    (int'(i_tap_lane) < NUM_LANES);
            m_load = m_ok;
            m_err  = (m_ops > 0) && !m_ok;
            if (m_ok) begin
                m_lane = int'(i_tap_lane);
                m_v = m_tap[m_lane];
                if (i_tap_inc) m_v = (m_v + 1 > (1 << TAP_W) - 1) ? m_v : m_v + 1;
                else if (i_tap_dec) m_v = (m_v == 0) ? 0 : m_v - 1;
                else m_v = int'(i_tap_value);
                m_tap[m_lane] = m_v;
            end
            if (i_recal) m_age = 0;
            else if (m_age < CAL_CYCLES) m_age++;
        end
    end

    logic [FW-1:0] m_flat;

    always @(negedge i_clk) begin
        if (started) begin
            for (int l = 0; l < NUM_LANES; l++) m_flat[l*TAP_W +: TAP_W] = TAP_W'(m_tap[l]);
            check("model_rdy", 128'(o_rdy), 128'(m_age >= CAL_CYCLES));
            check("model_flat", 128'(o_tap_flat), 128'(m_flat));
            check("model_load", 128'(o_tap_load), 128'(m_load));
            check("model_load_lane", 128'(o_tap_load_lane), 128'(m_lane));
            check("model_err", 128'(o_err), 128'(m_err));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic write(input int lane, input int value);
        i_tap_wr_en = 1'b1;
        i_tap_lane  = 4'(lane);
        i_tap_value = TAP_W'(value);
        tick();
        i_tap_wr_en = 1'b0;
    endtask

    logic [FW-1:0] all_default;

    initial begin
        all_default = {NUM_LANES{9'd256}};
        @(posedge i_clk);
        started = 1'b1;
        repeat (2) @(posedge i_clk);
        #2;
        check("reset_rdy", 128'(o_rdy), 128'(0));
        check("reset_flat", 128'(o_tap_flat), 128'(all_default));
        i_rst = 1'b0;

        // Calibration interval after release
        repeat (63) tick();
        check("rdy_low_edge63", 128'(o_rdy), 128'(0));
        tick();
        check("rdy_high_edge64", 128'(o_rdy), 128'(1));
        check("flat_after_cal", 128'(o_tap_flat), 128'(all_default));

        // Accepted write lane 3
        write(3, 100);
        check("lane3_value", 128'(o_tap_flat[35:27]), 128'(100));
        check("lane3_load", 128'(o_tap_load), 128'(1));
        check("lane3_load_lane", 128'(o_tap_load_lane), 128'(3));
        check("lane2_untouched", 128'(o_tap_flat[26:18]), 128'(256));
        tick();
        check("load_one_cycle", 128'(o_tap_load), 128'(0));

        // Out-of-range lane
        write(11, 5);
        check("bad_lane_err", 128'(o_err), 128'(1));
        check("bad_lane_noload", 128'(o_tap_load), 128'(0));
        check("bad_lane_keeps_lane", 128'(o_tap_load_lane), 128'(3));
        tick();
        check("err_one_cycle", 128'(o_err), 128'(0));

        // Recal with coincident write to lane 0
        i_recal = 1'b1;
        write(0, 7);
        i_recal = 1'b0;
        check("recal_rdy_low", 128'(o_rdy), 128'(0));
        check("recal_err", 128'(o_err), 128'(1));
        check("recal_lane0_kept", 128'(o_tap_flat[8:0]), 128'(256));
        write(1, 9);
        check("cal_write_err", 128'(o_err), 128'(1));
        check("cal_write_noload", 128'(o_tap_load), 128'(0));
        repeat (62) tick();
        check("recal_rdy_edge63", 128'(o_rdy), 128'(0));
        tick();
        check("recal_rdy_edge64", 128'(o_rdy), 128'(1));
        check("lane3_retained", 128'(o_tap_flat[35:27]), 128'(100));

        // Recal held high keeps the block calibrating
        i_recal = 1'b1;
        repeat (5) tick();
        i_recal = 1'b0;
        check("recal_held_rdy", 128'(o_rdy), 128'(0));
        repeat (64) tick();

        // Back-to-back writes over every lane, then a repeated value
        for (int l = 0; l < NUM_LANES; l++) begin
            i_tap_wr_en = 1'b1;
            i_tap_lane  = 4'(l);
            i_tap_value = TAP_W'(l * 10 + 1);
            tick();
        end
        i_tap_wr_en = 1'b0;
        check("b2b_lane10", 128'(o_tap_flat[98:90]), 128'(101));
        write(4, 41);
        check("repeat_same_load", 128'(o_tap_load), 128'(1));
        check("repeat_same_value", 128'(o_tap_flat[44:36]), 128'(41));

`ifdef IDELAY_TAP_INCDEC_EN
        write(2, 511);
        i_tap_inc = 1'b1; tick(); i_tap_inc = 1'b0;
        check("inc_sat_value", 128'(o_tap_flat[26:18]), 128'(511));
        check("inc_sat_load", 128'(o_tap_load), 128'(1));
        write(2, 0);
        i_tap_dec = 1'b1; tick(); i_tap_dec = 1'b0;
        check("dec_sat_value", 128'(o_tap_flat[26:18]), 128'(0));
        i_tap_inc = 1'b1;
        write(2, 50);
        i_tap_inc = 1'b0;
        check("inc_wr_err", 128'(o_err), 128'(1));
        check("inc_wr_keep", 128'(o_tap_flat[26:18]), 128'(0));
        i_tap_lane = 4'd6;
        i_tap_inc  = 1'b1; tick(); i_tap_inc = 1'b0;
        check("inc_lane6", 128'(o_tap_flat[62:54]), 128'(62));
`endif

        // Asynchronous reset mid-write
        i_tap_wr_en = 1'b1;
        i_tap_lane  = 4'd5;
        i_tap_value = 9'd33;
        tick();
        check("pre_reset_load", 128'(o_tap_load), 128'(1));
        #1 i_rst = 1'b1;
        #1;
        check("async_rst_rdy", 128'(o_rdy), 128'(0));
        check("async_rst_load", 128'(o_tap_load), 128'(0));
        check("async_rst_lane", 128'(o_tap_load_lane), 128'(0));
        check("async_rst_flat", 128'(o_tap_flat), 128'(all_default));
        i_tap_wr_en = 1'b0;
        tick();
        i_rst = 1'b0;
        repeat (66) tick();
        check("rdy_after_rerst", 128'(o_rdy), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
